pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
Controls the 32-bit program counter register in the IPF stage. It generates the PC write enable and the next PC value, and it drives the instruction-fetch request handshake toward the I-side bus interface. It arbitrates between sequential fetch, branch redirects (with the MIPS delay slot honoured), ERET and exception redirects. Redirects that arrive while a request is outstanding are buffered, so a fetch address never changes mid-handshake.

Parameters:
RESET_PC, 32'hBFC00000, boot vector (documentation only; the PC register owns the reset value)
PC_STEP, 32'd4, sequential increment

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
pc_cur  in  32  current PC from the PC register
wpc  out  1  PC write enable
pc_next  out  32  value written to PC when wpc=1
if_req  out  1  fetch request; address is pc_cur
if_addr_ok  in  1  bus accepted the request this cycle
stall  in  1  downstream backpressure; blocks new requests only
exc_valid  in  1  exception redirect (1-cycle pulse)
exc_target  in  32  exception vector
eret_valid  in  1  ERET redirect (pulse)
epc  in  32  ERET target
br_valid  in  1  taken branch/jump resolved (pulse)
br_target  in  32  branch target
br_slot_done  in  1  delay-slot fetch already accepted when br_valid=1
if_flush  out  1  1-cycle pulse when a redirect is applied; discard wrong-path fetches

Behaviour:
- Reset state: FSM=BOOT. wpc=0, if_req=0, if_flush=0, pc_next=RESET_PC, all pending state cleared. BOOT lasts exactly one cycle after rst deasserts, then the FSM goes to RUN.
- States:
  - BOOT: described above.
  - RUN: no request outstanding.
  - WAIT: if_req is high and not yet accepted.
- Pending registers:
  - pend_v and pend_pc: a buffered redirect.
  - slot_v: the buffered redirect must wait for the delay-slot fetch.
- if_req:
  - RUN: if_req = !stall && !(pend_v && !slot_v).
  - WAIT: if_req = 1 unconditionally. stall is ignored and the address stays pc_cur.
- Handshake: if_req && if_addr_ok means accepted. On acceptance wpc=1 and the FSM goes to RUN. pc_next is pend_pc if pend_v, otherwise pc_cur+PC_STEP (mod 2^32; 32'hFFFFFFFC wraps to 0). If acceptance consumes pend_v, if_flush=1 and pend_v and slot_v clear.
- If if_req is high and if_addr_ok is low in RUN, the FSM goes to WAIT.
- Redirect priority within a cycle is exc > eret > br. A new higher-priority event overwrites pend_pc and clears slot_v for exc and eret. A branch never overwrites an exception or ERET that is already pending.
- Applying an exception or ERET:
  - RUN with no acceptance this cycle: apply immediately. wpc=1, pc_next=target, if_flush=1, if_req forced to 0 that cycle.
  - WAIT: store in pend_pc with pend_v=1, and apply on acceptance.
- Applying a branch:
  - br_slot_done=1: treated like an exception (immediate in RUN, buffered in WAIT).
  - br_slot_done=0: pend_pc=br_target, pend_v=1, slot_v=1. The next acceptance fetches the slot at pc_cur, and on that acceptance pc_next=pend_pc with if_flush=0 (the slot is valid). slot_v and pend_v then clear.
- If a redirect event arrives in the same cycle as an acceptance, the event wins over the existing pending target for pc_next, following the rules above.
- stall has no effect on wpc in the immediate-apply path.
- Asynchronous reset mid-WAIT abandons the request. The bus side is reset in the same domain.
- wpc is never asserted in BOOT.

Decomposition:
- Shared package (ipf_pkg):
  - state encoding: BOOT, RUN, WAIT
  - RESET_PC
  - PC_STEP
  - redirect-source enum: NONE, EXC, ERET, BR
- Natural sub-module: redirect_buffer (pend_v, pend_pc, slot_v, plus priority merge). The FSM and handshake stay in the top module.

Test Plan:
- Boot: rst released, pc_cur=BFC00000, if_addr_ok=1 from cycle 2 -> if_req=0 in BOOT; if_req=1 then wpc=1 with pc_next=BFC00004, BFC00008 on consecutive cycles.
- Handshake hold: if_addr_ok=0 for 3 cycles with stall=1 during WAIT -> if_req stays 1 and wpc=0 throughout; on acceptance pc_next=pc_cur+4.
- Delay slot: br_valid with br_slot_done=0, br_target=BFC00100, pc_cur=BFC00010 -> next acceptance fetches BFC00010, pc_next=BFC00100, if_flush=0.
- Exception in WAIT: exc_target=BFC00380 arrives while waiting -> held until if_addr_ok; then pc_next=BFC00380 and if_flush=1. An immediate exception in RUN gives wpc=1 and if_req=0 in the same cycle.
- Priority: exc_valid, eret_valid and br_valid in the same cycle (80000180, 80001000, 80002000) -> pc_next=80000180. A later branch while the exception is pending leaves 80000180 unchanged.
- Wrap and reset: pc_cur=FFFFFFFC accepted -> pc_next=00000000. rst asserted mid-WAIT -> outputs immediately return to reset values.

Source files
------------

// File: rtl/ipf_pkg.sv
// Shared types and constants for the IPF-stage PC fetch sequencer.
package ipf_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {BOOT, RUN, WAIT} fsm_state_e;

  typedef enum logic [1:0] {NONE, EXC, ERET, BR} redir_src_e;

  typedef struct packed {
    logic       v;
    logic       slot;
    redir_src_e src;
    logic [31:0] pc;
  } redir_t;

endpackage

// File: rtl/redirect_buffer.sv
// Holds one pending redirect and merges this cycle's redirect events into it
// with exc > eret > br priority.
module redirect_buffer
  import ipf_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ev_en,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        br_slot_done,
  input  logic        clr,
  output logic        pend_v,
  output logic        slot_v,
  output logic        m_v,
  output logic        m_slot,
  output logic [31:0] m_pc
);

  redir_t pend_q, ev, merged;

  always_comb begin
    ev = '0;
    if (ev_en) begin
      if (exc_valid) begin
        ev.v   = 1'b1;
        ev.src = EXC;
        ev.pc  = exc_target;
      end else if (eret_valid) begin
        ev.v   = 1'b1;
        ev.src = ERET;
        ev.pc  = epc;
      end else if (br_valid && !(pend_q.v && pend_q.src != BR)) begin
        // a branch may replace an older branch, never a pending exc/eret
        ev.v    = 1'b1;
        ev.slot = !br_slot_done;
        ev.src  = BR;
        ev.pc   = br_target;
      end
    end
    merged = ev.v ? ev : pend_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      pend_q <= '0;
    else if (clr) pend_q <= '0;
    else          pend_q <= merged;
  end

  assign pend_v = pend_q.v;
  assign slot_v = pend_q.slot;
  assign m_v    = merged.v;
  assign m_slot = merged.slot;
  assign m_pc   = merged.pc;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// IPF-stage PC sequencer: fetch handshake FSM, PC write enable / next PC,
// and redirect application (exc, eret, branch with delay slot).
module pc_fetch_sequencer
  import ipf_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic        wpc,
  output logic [31:0] pc_next,
  output logic        if_req,
  input  logic        if_addr_ok,
  input  logic        stall,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        br_slot_done,
  output logic        if_flush
);

  fsm_state_e  state, state_d;
  logic        pend_v, slot_v, m_v, m_slot;
  logic [31:0] m_pc, pc_seq;
  logic        consume, imm;

  redirect_buffer u_rbuf (
    .clk          (clk),
    .rst          (rst),
    .ev_en        (state != BOOT),
    .exc_valid    (exc_valid),
    .exc_target   (exc_target),
    .eret_valid   (eret_valid),
    .epc          (epc),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .br_slot_done (br_slot_done),
    .clr          (consume),
    .pend_v       (pend_v),
    .slot_v       (slot_v),
    .m_v          (m_v),
    .m_slot       (m_slot),
    .m_pc         (m_pc)
  );

  assign pc_seq = pc_cur + PC_STEP;

  always_comb begin
    state_d  = state;
    if_req   = 1'b0;
    wpc      = 1'b0;
    if_flush = 1'b0;
    pc_next  = RESET_PC;
    consume  = 1'b0;
    imm      = 1'b0;
    case (state)
      BOOT: begin
        state_d = RUN;
        consume = 1'b1;
      end
      RUN: begin
        // non-slot redirect with nothing in flight: apply now, no request
        imm      = m_v && !m_slot;
        if_req   = !stall && !(pend_v && !slot_v) && !imm;
        wpc      = imm || (if_req && if_addr_ok);
        pc_next  = m_v ? m_pc : pc_seq;
        if_flush = imm;
        consume  = wpc;
        state_d  = (if_req && !if_addr_ok) ? WAIT : RUN;
      end
      WAIT: begin
        if_req   = 1'b1;
        wpc      = if_addr_ok;
        pc_next  = m_v ? m_pc : pc_seq;
        // a slot redirect keeps the accepted fetch, so no flush for it
        if_flush = if_addr_ok && m_v && !m_slot;
        consume  = if_addr_ok;
        state_d  = if_addr_ok ? RUN : WAIT;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_d;
  end

endmodule
